// File: rtl/lcd_pkg.sv
// Shared types and default timing constants for the LCD line/frame sequencer.
package lcd_pkg;

    // STAT mode encoding as seen by software in STAT[1:0].
    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } lcd_mode_t;

    // Default frame geometry in dots and lines.
    localparam int DEF_DOTS_PER_LINE   = 456;
    localparam int DEF_LINES_PER_FRAME = 154;
    localparam int DEF_VISIBLE_LINES   = 144;
    localparam int DEF_OAM_DOTS        = 80;
    localparam int DEF_XFER_MAX_DOTS   = 289;

    // Bit positions inside the STAT interrupt enable field.
    localparam int STAT_IE_MODE0 = 0;
    localparam int STAT_IE_MODE1 = 1;
    localparam int STAT_IE_MODE2 = 2;
    localparam int STAT_IE_LYC   = 3;

endpackage

// File: rtl/lcd_stat_irq.sv
// STAT interrupt line: OR of the enabled sources, then a rising-edge detect
// so a line that stays high across a mode change does not re-trigger.
module lcd_stat_irq
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_srst,
    input  lcd_mode_t  i_mode,
    input  logic       i_lyc_match,
    input  logic [3:0] i_stat_ie,
    output logic       o_int_stat
);

    logic w_stat_line;
    logic r_stat_line_prev;
    logic r_int_stat;

    // Combine every enabled STAT source into the single shared line.
    always_comb begin
        w_stat_line = (i_stat_ie[STAT_IE_MODE0] && (i_mode == MODE_HBLANK))
                    | (i_stat_ie[STAT_IE_MODE1] && (i_mode == MODE_VBLANK))
                    | (i_stat_ie[STAT_IE_MODE2] && (i_mode == MODE_OAM))
                    | (i_stat_ie[STAT_IE_LYC]   && i_lyc_match);
    end

    // Remember the previous line level and emit a pulse only on its rise.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_stat_line_prev <= 1'b0;
            r_int_stat       <= 1'b0;
        end else begin
            r_stat_line_prev <= w_stat_line;
            r_int_stat       <= w_stat_line & ~r_stat_line_prev;
        end
    end

    assign o_int_stat = r_int_stat;

endmodule

// File: rtl/lcd_timing_seq.sv
// Dot/line counters, STAT mode FSM and pacing strobes for the LCD path.
module lcd_timing_seq
    import lcd_pkg::*;
#(
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
    parameter int OAM_DOTS        = DEF_OAM_DOTS,
    parameter int XFER_MAX_DOTS   = DEF_XFER_MAX_DOTS
) (
    input  logic       clk2,
    input  logic       reset_video,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    input  logic       xfer_done,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       pipe_run,
    output logic       line_start,
    output logic       frame_start,
    output logic       int_vblank,
    output logic       int_stat
);

    localparam logic [8:0] LP_DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LP_LINE_LAST = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LP_VBL_LINE  = 8'(VISIBLE_LINES);
    localparam logic [8:0] LP_XFER_DOT  = 9'(OAM_DOTS);
    localparam logic [8:0] LP_XFER_END  = 9'(OAM_DOTS + XFER_MAX_DOTS);

    // Held in reset whenever the panel is off.
    logic       w_srst;
    logic       r_running;
    logic [7:0] r_ly;
    logic [8:0] r_dot;
    lcd_mode_t  r_mode;
    logic       r_lyc_match;
    logic       r_pipe_run;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_int_vblank;

    logic [7:0] w_ly_next;
    logic [8:0] w_dot_next;
    lcd_mode_t  w_mode_next;
    logic       w_line_start_next;

    assign w_srst = reset_video | ~lcd_en;

    // Next counter position and mode, all derived from the upcoming dot/line.
    always_comb begin
        w_ly_next   = r_ly;
        w_dot_next  = r_dot + 9'd1;
        w_mode_next = r_mode;
        if (!r_running) begin
            // First enabled edge lands on line 0, dot 0.
            w_ly_next  = 8'd0;
            w_dot_next = 9'd0;
        end else if (r_dot == LP_DOT_LAST) begin
            w_dot_next = 9'd0;
            w_ly_next  = (r_ly == LP_LINE_LAST) ? 8'd0 : r_ly + 8'd1;
        end

        if (w_ly_next >= LP_VBL_LINE) begin
            w_mode_next = MODE_VBLANK;
        end else if (w_dot_next == 9'd0) begin
            w_mode_next = MODE_OAM;
        end else if (w_dot_next == LP_XFER_DOT) begin
            w_mode_next = MODE_XFER;
        end else if ((r_mode == MODE_XFER) &&
                     (xfer_done || (w_dot_next == LP_XFER_END))) begin
            // Pixel pipe finished, or it stalled and the timeout ends the line.
            w_mode_next = MODE_HBLANK;
        end

        w_line_start_next = (w_dot_next == 9'd0);
    end

    // State register; every output is taken straight from a flop.
    always_ff @(posedge clk2) begin
        if (w_srst) begin
            r_running     <= 1'b0;
            r_ly          <= 8'd0;
            r_dot         <= 9'd0;
            r_mode        <= MODE_HBLANK;
            r_lyc_match   <= 1'b0;
            r_pipe_run    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_int_vblank  <= 1'b0;
        end else begin
            r_running     <= 1'b1;
            r_ly          <= w_ly_next;
            r_dot         <= w_dot_next;
            r_mode        <= w_mode_next;
            r_lyc_match   <= (r_ly == lyc);
            r_pipe_run    <= (w_mode_next == MODE_XFER);
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_line_start_next && (w_ly_next == 8'd0);
            r_int_vblank  <= w_line_start_next && (w_ly_next == LP_VBL_LINE);
        end
    end

    lcd_stat_irq u_stat_irq (
        .i_clk       (clk2),
        .i_srst      (w_srst),
        .i_mode      (r_mode),
        .i_lyc_match (r_lyc_match),
        .i_stat_ie   (stat_ie),
        .o_int_stat  (int_stat)
    );

    assign ly          = r_ly;
    assign dot         = r_dot;
    assign mode        = r_mode;
    assign lyc_match   = r_lyc_match;
    assign pipe_run    = r_pipe_run;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign int_vblank  = r_int_vblank;

endmodule

// File: tb/tb_lcd_timing_seq.sv
// Directed bench for lcd_timing_seq: counters, mode FSM, strobes and IRQs.
module tb_lcd_timing_seq;

    logic       clk2 = 1'b0;
    logic       reset_video;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       xfer_done;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       lyc_match;
    logic       pipe_run;
    logic       line_start;
    logic       frame_start;
    logic       int_vblank;
    logic       int_stat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc0   = 0;
    int n_vbl  = 0;
    int n_stat = 0;

    lcd_timing_seq dut (
        .clk2        (clk2),
        .reset_video (reset_video),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .stat_ie     (stat_ie),
        .xfer_done   (xfer_done),
        .ly          (ly),
        .dot         (dot),
        .mode        (mode),
        .lyc_match   (lyc_match),
        .pipe_run    (pipe_run),
        .line_start  (line_start),
        .frame_start (frame_start),
        .int_vblank  (int_vblank),
        .int_stat    (int_stat)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk2);
        #1;
        cyc++;
        if (int_vblank) n_vbl++;
        if (int_stat)   n_stat++;
    endtask

    // Advance until (ly, dot) is reached, bounded so a broken counter cannot hang.
    task automatic run_to(input int t_ly, input int t_dot);
        int n = 0;
        while (!(int'(ly) == t_ly && int'(dot) == t_dot) && n < 80000) begin
            tick();
            n++;
        end
        chk("run_to_reached", {31'd0, (int'(ly) == t_ly && int'(dot) == t_dot)}, 32'd1);
    endtask

    initial begin
        reset_video = 1'b1;
        lcd_en      = 1'b0;
        lyc         = 8'd200;
        stat_ie     = 4'b0000;
        xfer_done   = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_ly", ly, 0);
        chk("rst_dot", dot, 0);
        chk("rst_mode", mode, 0);
        chk("rst_pipe_run", pipe_run, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_lyc_match", lyc_match, 0);

        // 1. Enable: line 0 dot 0 in mode 2 with both start strobes
        reset_video = 1'b0;
        lcd_en      = 1'b1;
        tick();
        chk("en_dot", dot, 0);
        chk("en_ly", ly, 0);
        chk("en_mode", mode, 2);
        chk("en_frame_start", frame_start, 1);
        chk("en_line_start", line_start, 1);
        tick();
        chk("dot1_dot", dot, 1);
        chk("dot1_frame_start", frame_start, 0);
        chk("dot1_line_start", line_start, 0);
        run_to(0, 79);
        chk("dot79_mode", mode, 2);
        tick();
        chk("dot80_mode", mode, 3);
        chk("dot80_pipe_run", pipe_run, 1);

        // 2. xfer_done at dot 252 ends mode 3; a second one in mode 0 does nothing
        run_to(0, 252);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("xd_dot", dot, 253);
        chk("xd_mode", mode, 0);
        chk("xd_pipe_run", pipe_run, 0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("xd2_mode", mode, 0);
        chk("xd2_pipe_run", pipe_run, 0);
        run_to(0, 455);
        chk("l0_end_ly", ly, 0);
        chk("l0_end_mode", mode, 0);
        tick();
        chk("l1_ly", ly, 1);
        chk("l1_dot", dot, 0);
        chk("l1_mode", mode, 2);
        chk("l1_line_start", line_start, 1);
        chk("l1_frame_start", frame_start, 0);

        // xfer_done during mode 2 is ignored
        run_to(1, 40);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("xd_oam_mode", mode, 2);
        run_to(1, 80);
        chk("l1_dot80_mode", mode, 3);

        // 3. No xfer_done: forced to mode 0 at dot 369
        run_to(1, 368);
        chk("to368_mode", mode, 3);
        chk("to368_pipe_run", pipe_run, 1);
        tick();
        chk("to369_mode", mode, 0);
        chk("to369_pipe_run", pipe_run, 0);

        // 5. LYC match interrupt, then STAT blocking across the hblank entry
        lyc     = 8'd5;
        stat_ie = 4'b1000;
        n_stat  = 0;
        run_to(5, 0);
        chk("lyc_l5d0_match", lyc_match, 0);
        chk("lyc_pre_stat_cnt", n_stat, 0);
        tick();
        chk("lyc_l5d1_match", lyc_match, 1);
        chk("lyc_l5d1_int_stat", int_stat, 0);
        tick();
        chk("lyc_l5d2_int_stat", int_stat, 1);
        tick();
        chk("lyc_l5d3_int_stat", int_stat, 0);
        stat_ie = 4'b1001;
        n_stat  = 0;
        run_to(5, 455);
        chk("blocked_mode", mode, 0);
        chk("blocked_stat_cnt", n_stat, 0);
        run_to(6, 369);
        chk("l6_hbl_mode", mode, 0);
        chk("l6_hbl_int_stat_early", int_stat, 0);
        tick();
        chk("l6_hbl_int_stat", int_stat, 1);
        stat_ie = 4'b0000;

        // 6. LCD off mid-line clears everything on the next edge
        lyc = 8'd7;
        run_to(7, 200);
        chk("off_pre_lyc_match", lyc_match, 1);
        lcd_en = 1'b0;
        tick();
        chk("off_ly", ly, 0);
        chk("off_dot", dot, 0);
        chk("off_mode", mode, 0);
        chk("off_lyc_match", lyc_match, 0);
        chk("off_pipe_run", pipe_run, 0);
        chk("off_pulses", {28'd0, line_start, frame_start, int_vblank, int_stat}, 0);
        tick();
        chk("off2_dot", dot, 0);
        lcd_en = 1'b1;
        lyc    = 8'd200;
        tick();
        chk("reen_ly", ly, 0);
        chk("reen_dot", dot, 0);
        chk("reen_mode", mode, 2);
        chk("reen_frame_start", frame_start, 1);
        cyc0  = cyc;
        n_vbl = 0;

        // 4. Vblank entry (mode-2 enable must not fire), frame wrap and length
        run_to(143, 100);
        chk("pre_vbl_cnt", n_vbl, 0);
        stat_ie = 4'b0100;
        n_stat  = 0;
        run_to(144, 0);
        chk("vbl_int_vblank", int_vblank, 1);
        chk("vbl_mode", mode, 1);
        chk("vbl_pipe_run", pipe_run, 0);
        tick();
        chk("vbl_int_vblank_end", int_vblank, 0);
        run_to(144, 10);
        chk("vbl_no_mode2_stat", n_stat, 0);
        stat_ie = 4'b0000;
        run_to(153, 455);
        chk("l153_mode", mode, 1);
        tick();
        chk("wrap_ly", ly, 0);
        chk("wrap_dot", dot, 0);
        chk("wrap_mode", mode, 2);
        chk("wrap_frame_start", frame_start, 1);
        chk("frame_len", cyc - cyc0, 70224);
        chk("vbl_pulse_cnt", n_vbl, 1);

        // Reset mid-line aborts at once and restarts cleanly
        run_to(0, 50);
        reset_video = 1'b1;
        tick();
        chk("rst_mid_dot", dot, 0);
        chk("rst_mid_mode", mode, 0);
        chk("rst_mid_frame_start", frame_start, 0);
        reset_video = 1'b0;
        tick();
        chk("rst_rel_mode", mode, 2);
        chk("rst_rel_frame_start", frame_start, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
